piso_serializer: RTL



---
 rtl/piso_pkg.sv | 17 +
 rtl/piso_serializer.sv | 106 ++++++++++
 2 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared types and helpers for the parallel-in serial-out serializer.
// Holds the FSM state encoding and the bit-counter width helper.
package piso_pkg;

    // PARITY stays in the enum even when parity is compiled out,
    // so the state encoding is identical across builds.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: accepts a WIDTH-bit word over a valid/ready handshake and
// shifts it out MSB-first, one bit per clock, qualified by serial_valid.
// Ports:
//   clk, reset (async, active-high)
//   load_data/load_valid/load_ready : word input handshake
//   serial_out/serial_valid         : serial bit stream
//   frame_start/frame_done          : first / last bit markers
// Optional: define PISO_PARITY_EN to append one even-parity bit per frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_done
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    piso_state_t      state;
    piso_state_t      state_d;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             par;
`endif

    always_comb begin
        state_d      = state;
        load_ready   = 1'b0;
        serial_out   = 1'b0;
        serial_valid = 1'b0;
        frame_start  = 1'b0;
        frame_done   = 1'b0;
        unique case (state)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                serial_out   = shreg[WIDTH-1];
                serial_valid = 1'b1;
                frame_start  = (cnt == CNT_TOP);
`ifdef PISO_PARITY_EN
                if (cnt == '0) state_d = PARITY;
`else
                frame_done = (cnt == '0);
                load_ready = (cnt == '0);
                if (cnt == '0) state_d = IDLE;
`endif
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                serial_out   = par;
                serial_valid = 1'b1;
                frame_done   = 1'b1;
                load_ready   = 1'b1;
                state_d      = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
        // Nothing may be accepted while reset is held.
        if (reset) load_ready = 1'b0;
        accept = load_valid && load_ready;
        // A handshake in IDLE or in the final frame cycle starts a frame.
        if (accept) state_d = SHIFT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
`ifdef PISO_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (accept) begin
            shreg <= load_data;
            cnt   <= CNT_TOP;
`ifdef PISO_PARITY_EN
            par   <= ^load_data;
`endif
        end else if (state == SHIFT) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            // Hold at zero so the counter never wraps on frame exit.
            if (cnt != '0) cnt <= cnt - CW'(1);
        end
    end

endmodule
